// File: rtl/hazard_redirect_ctrl_pkg.sv
// Shared types and encodings for the hazard/forwarding controller.
// Holds the forwarding selects, the FSM states, the shadow entry and its match test.
package hazard_redirect_ctrl_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned SEL_W = 2;

  localparam logic [SEL_W-1:0] SEL_RF    = 2'b00;
  localparam logic [SEL_W-1:0] SEL_EXMEM = 2'b01;
  localparam logic [SEL_W-1:0] SEL_MEMWB = 2'b10;

  typedef enum logic {
    RUN      = 1'b0,
    LU_STALL = 1'b1
  } state_e;

  typedef struct packed {
    logic             valid;
    logic             wr;
    logic [REG_W-1:0] dst;
    logic             load;
  } shadow_t;

  localparam shadow_t SHADOW_BUBBLE = '0;

  // A source operand depends on an in-flight entry; r0 never creates a dependency.
  function automatic logic entry_match(input shadow_t e, input logic [REG_W-1:0] src,
                                       input logic use_src);
    return e.valid && e.wr && (e.dst == src) && (src != '0) && use_src;
  endfunction

endpackage

// File: rtl/hazard_redirect_ctrl_if.sv
// ID-stage request and hazard/forwarding response bundle.
// master drives the ID instruction fields; slave is the hazard controller.
interface hazard_redirect_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  import hazard_redirect_ctrl_pkg::*;

  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             id_wr;
  logic [REG_W-1:0] id_wdst;
  logic             id_load;
  logic             ex_taken;

  logic [SEL_W-1:0] rfd1sel;
  logic [SEL_W-1:0] rfd2sel;
  logic             stall;
  logic             pc_en;
  logic             flush;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr, id_wdst, id_load, ex_taken,
    input  rfd1sel, rfd2sel, stall, pc_en, flush, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr, id_wdst, id_load, ex_taken,
    output rfd1sel, rfd2sel, stall, pc_en, flush, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_redirect_ctrl_src_match.sv
// Per-operand dependency check against the EX/MEM/WB shadow entries.
// Youngest match wins; a load in EX gives no forward path and reports a load-use hit.
module hazard_src_match
  import hazard_redirect_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] src,
  input  logic             use_src,
  input  shadow_t          ex,
  input  shadow_t          mem,
  input  shadow_t          wb,
  output logic [SEL_W-1:0] sel_c,
  output logic             lu_hit_c
);

  logic ex_hit_c;
  logic mem_hit_c;
  logic wb_hit_c;

  assign ex_hit_c  = entry_match(ex,  src, use_src);
  assign mem_hit_c = entry_match(mem, src, use_src);
  assign wb_hit_c  = entry_match(wb,  src, use_src);
  assign lu_hit_c  = ex_hit_c && ex.load;

  always_comb begin
    sel_c = SEL_RF;
    if (ex_hit_c) begin
      sel_c = ex.load ? SEL_RF : SEL_EXMEM;
    end else if (mem_hit_c) begin
      sel_c = SEL_MEMWB;
    end else if (wb_hit_c) begin
      // The register file writes before it reads, so WB needs no bypass.
      sel_c = SEL_RF;
    end
  end

endmodule

// File: rtl/hazard_redirect_ctrl.sv
// Hazard and forwarding controller: shadow EX/MEM/WB destinations, load-use stall,
// taken-branch flush and saturating stall/flush event counters.
module hazard_redirect_ctrl
  import hazard_redirect_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  hazard_redirect_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  shadow_t          ex_q, mem_q, wb_q;
  shadow_t          id_entry;
  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel1_c, sel2_c;
  logic             lu1_c, lu2_c;
  logic             load_use_c, stall_c, flush_c;
  logic             assert_fail;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  hazard_src_match u_src_rs (
    .src      (bus.id_rs),
    .use_src  (bus.id_use_rs),
    .ex       (ex_q),
    .mem      (mem_q),
    .wb       (wb_q),
    .sel_c    (sel1_c),
    .lu_hit_c (lu1_c)
  );

  hazard_src_match u_src_rt (
    .src      (bus.id_rt),
    .use_src  (bus.id_use_rt),
    .ex       (ex_q),
    .mem      (mem_q),
    .wb       (wb_q),
    .sel_c    (sel2_c),
    .lu_hit_c (lu2_c)
  );

  assign id_entry = '{valid: bus.id_valid, wr: bus.id_wr, dst: bus.id_wdst, load: bus.id_load};

  // Hazard decode and FSM next state; a taken branch overrides the load-use stall.
  always_comb begin
    state_d     = state_q;
    load_use_c  = bus.id_valid && (lu1_c || lu2_c);
    flush_c     = bus.ex_taken;
    stall_c     = load_use_c && !flush_c;
    assert_fail = (state_q == LU_STALL) && load_use_c;
    case (state_q)
      RUN:      if (stall_c) state_d = LU_STALL;
      LU_STALL: state_d = RUN;
    endcase
  end

  assign bus.rfd1sel   = stall_c ? SEL_RF : sel1_c;
  assign bus.rfd2sel   = stall_c ? SEL_RF : sel2_c;
  assign bus.stall     = stall_c;
  assign bus.pc_en     = !stall_c;
  assign bus.flush     = flush_c;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;

  // Shadow pipeline advances every edge; stalled or flushed ID enters as a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= SHADOW_BUBBLE;
      mem_q   <= SHADOW_BUBBLE;
      wb_q    <= SHADOW_BUBBLE;
      state_q <= RUN;
    end else begin
      wb_q    <= mem_q;
      mem_q   <= ex_q;
      ex_q    <= (!stall_c && !flush_c) ? id_entry : SHADOW_BUBBLE;
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_c && (stall_cnt_q != CNT_MAX)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_c && (flush_cnt_q != CNT_MAX)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  // The post-stall bubble leaves EX empty, so a back-to-back load-use cannot occur.
  a_no_double_stall: assert property (@(posedge clk) disable iff (!rst_n) !assert_fail);

endmodule

// File: tb/tb_hazard_redirect_ctrl.sv
// Directed table-driven bench for hazard_redirect_ctrl plus multi-cycle sequences
// for counter saturation (narrow-counter instance) and reset in the middle of a stall.
module tb_hazard_redirect_ctrl;
  import hazard_redirect_ctrl_pkg::*;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  hazard_redirect_ctrl_if #(.CNT_W(16)) bus ();
  hazard_redirect_ctrl_if #(.CNT_W(2))  bus_s ();

  hazard_redirect_ctrl #(.CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  hazard_redirect_ctrl #(.CNT_W(2))  dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));

  assign bus_s.id_valid  = bus.id_valid;
  assign bus_s.id_rs     = bus.id_rs;
  assign bus_s.id_rt     = bus.id_rt;
  assign bus_s.id_use_rs = bus.id_use_rs;
  assign bus_s.id_use_rt = bus.id_use_rt;
  assign bus_s.id_wr     = bus.id_wr;
  assign bus_s.id_wdst   = bus.id_wdst;
  assign bus_s.id_load   = bus.id_load;
  assign bus_s.ex_taken  = bus.ex_taken;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       wr;
    logic [4:0] dst;
    logic       ld;
    logic       tk;
    logic [1:0] s1;
    logic [1:0] s2;
    logic       st;
    logic       fl;
  } vec_t;

  localparam int NV = 19;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic v, input int rs, input int rt, input logic urs,
                              input logic urt, input logic wr, input int dst, input logic ld,
                              input logic tk, input logic [1:0] s1, input logic [1:0] s2,
                              input logic st, input logic fl);
    vec_t r;
    r.v = v; r.rs = 5'(rs); r.rt = 5'(rt); r.urs = urs; r.urt = urt; r.wr = wr;
    r.dst = 5'(dst); r.ld = ld; r.tk = tk; r.s1 = s1; r.s2 = s2; r.st = st; r.fl = fl;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.id_valid  = v.v;
    bus.id_rs     = v.rs;
    bus.id_rt     = v.rt;
    bus.id_use_rs = v.urs;
    bus.id_use_rt = v.urt;
    bus.id_wr     = v.wr;
    bus.id_wdst   = v.dst;
    bus.id_load   = v.ld;
    bus.ex_taken  = v.tk;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " rfd1sel"},   32'(bus.rfd1sel),   32'd0);
    chk({tag, " rfd2sel"},   32'(bus.rfd2sel),   32'd0);
    chk({tag, " stall"},     32'(bus.stall),     32'd0);
    chk({tag, " pc_en"},     32'(bus.pc_en),     32'd1);
    chk({tag, " flush"},     32'(bus.flush),     32'd0);
    chk({tag, " stall_cnt"}, 32'(bus.stall_cnt), 32'd0);
    chk({tag, " flush_cnt"}, 32'(bus.flush_cnt), 32'd0);
    chk({tag, " small_cnt"}, 32'(bus_s.stall_cnt), 32'd0);
  endtask

  initial begin
    int   exp_sc;
    int   exp_fc;
    int   stalls;
    vec_t lw_plain;
    vec_t lw_dep;
    vec_t rd_r4;

    tests = 0;
    fails = 0;

    // Each row is one cycle of ID traffic; expectations follow the shadow pipeline history.
    //           v rs rt urs urt wr dst ld tk   s1     s2    st fl
    tbl[0]  = mk(1, 1, 2, 1, 1, 1, 3, 0, 0, 2'b00, 2'b00, 0, 0); // add r3
    tbl[1]  = mk(1, 3, 1, 1, 1, 1, 5, 0, 0, 2'b01, 2'b00, 0, 0); // sub r5,r3,r1
    tbl[2]  = mk(1, 8, 9, 1, 1, 1, 7, 0, 0, 2'b00, 2'b00, 0, 0);
    tbl[3]  = mk(1, 1, 2, 1, 1, 1, 10, 0, 0, 2'b00, 2'b00, 0, 0); // producer r10
    tbl[4]  = mk(1, 12, 13, 1, 1, 1, 11, 0, 0, 2'b00, 2'b00, 0, 0); // unrelated
    tbl[5]  = mk(1, 5, 10, 1, 1, 1, 14, 0, 0, 2'b00, 2'b10, 0, 0); // r10 as rt from MEM
    tbl[6]  = mk(1, 1, 0, 1, 0, 1, 4, 1, 0, 2'b00, 2'b00, 0, 0); // lw r4
    tbl[7]  = mk(1, 4, 4, 1, 1, 1, 6, 0, 0, 2'b00, 2'b00, 1, 0); // add r6,r4,r4 stalls
    tbl[8]  = mk(1, 4, 4, 1, 1, 1, 6, 0, 0, 2'b10, 2'b10, 0, 0); // replay forwards from MEM
    tbl[9]  = mk(1, 1, 2, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0); // writer of r0
    tbl[10] = mk(1, 0, 0, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0); // reader of r0
    tbl[11] = mk(1, 1, 2, 1, 1, 1, 20, 0, 0, 2'b00, 2'b00, 0, 0); // add r20
    tbl[12] = mk(1, 20, 20, 0, 1, 0, 0, 0, 0, 2'b00, 2'b01, 0, 0); // rs unused
    tbl[13] = mk(1, 1, 0, 1, 0, 1, 4, 1, 0, 2'b00, 2'b00, 0, 0); // lw r4
    tbl[14] = mk(1, 4, 4, 1, 1, 1, 9, 0, 1, 2'b00, 2'b00, 0, 1); // load-use + taken
    tbl[15] = mk(1, 9, 4, 1, 1, 0, 0, 0, 0, 2'b00, 2'b10, 0, 0); // flushed r9 not in EX
    tbl[16] = mk(1, 1, 0, 1, 0, 1, 4, 1, 0, 2'b00, 2'b00, 0, 0); // lw r4
    tbl[17] = mk(0, 4, 4, 1, 1, 1, 6, 0, 0, 2'b00, 2'b00, 0, 0); // invalid ID: no stall
    tbl[18] = mk(1, 4, 4, 1, 1, 0, 0, 0, 0, 2'b10, 2'b10, 0, 0);

    lw_plain = mk(1, 1, 0, 1, 0, 1, 4, 1, 0, 2'b00, 2'b00, 0, 0);
    lw_dep   = mk(1, 4, 0, 1, 0, 1, 4, 1, 0, 2'b00, 2'b00, 0, 0);
    rd_r4    = mk(1, 4, 4, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);

    rst_n = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    exp_sc = 0;
    exp_fc = 0;
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i]);
      @(negedge clk);
      chk($sformatf("row%0d rfd1sel", i),   32'(bus.rfd1sel),   32'(tbl[i].s1));
      chk($sformatf("row%0d rfd2sel", i),   32'(bus.rfd2sel),   32'(tbl[i].s2));
      chk($sformatf("row%0d stall", i),     32'(bus.stall),     32'(tbl[i].st));
      chk($sformatf("row%0d pc_en", i),     32'(bus.pc_en),     32'(!tbl[i].st));
      chk($sformatf("row%0d flush", i),     32'(bus.flush),     32'(tbl[i].fl));
      chk($sformatf("row%0d stall_cnt", i), 32'(bus.stall_cnt), 32'(exp_sc));
      chk($sformatf("row%0d flush_cnt", i), 32'(bus.flush_cnt), 32'(exp_fc));
      if (tbl[i].st) exp_sc++;
      if (tbl[i].fl) exp_fc++;
      @(posedge clk);
      #1;
    end

    // Alternating stalls from a chain of dependent loads; the 2-bit counter must saturate.
    drive(lw_plain);
    @(posedge clk);
    #1;
    stalls = 0;
    for (int i = 0; i < 10; i++) begin
      drive(lw_dep);
      @(negedge clk);
      chk($sformatf("sat%0d stall", i), 32'(bus.stall), 32'((i % 2) == 0));
      if ((i % 2) == 1) begin
        chk($sformatf("sat%0d rfd1sel", i), 32'(bus.rfd1sel), 32'(SEL_MEMWB));
        chk($sformatf("sat%0d stall_cnt", i), 32'(bus.stall_cnt), 32'(exp_sc + stalls));
        chk($sformatf("sat%0d small_cnt", i), 32'(bus_s.stall_cnt),
            32'((exp_sc + stalls) > 3 ? 3 : (exp_sc + stalls)));
      end
      if ((i % 2) == 0) stalls++;
      @(posedge clk);
      #1;
    end
    chk("sat small_cnt held", 32'(bus_s.stall_cnt), 32'd3);
    chk("sat stall_cnt final", 32'(bus.stall_cnt), 32'(exp_sc + 5));

    // Reset asserted while a load-use stall is being signalled.
    drive(rd_r4);
    @(negedge clk);
    chk("pre-reset stall", 32'(bus.stall), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midstall reset");
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_outputs("reset released");
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("post-reset stall", 32'(bus.stall), 32'd0);
    chk("post-reset stall_cnt", 32'(bus.stall_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hazard_redirect_ctrl.md
# hazard_redirect_ctrl

Hazard and forwarding controller for the five-stage redirect pipeline. It drives the ID/EX stage register from the other side of its control interface. Each cycle it compares the ID-stage instruction's source registers against a private shadow pipeline of in-flight destination registers in EX, MEM and WB. From that comparison it produces the forwarding selects `rfd1sel`/`rfd2sel`, the load-use `stall`, the PC enable, and the flush bubble on a taken branch. Two saturating counters record stall and flush cycles for performance debug.

## Interface
- `CNT_W`, 16: width of the stall and flush counters.
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `id_valid`  in  1  ID stage holds a real instruction.
- `id_rs`, `id_rt`  in  5  source register numbers of the ID instruction.
- `id_use_rs`, `id_use_rt`  in  1  the ID instruction actually reads rs / rt.
- `id_wr`  in  1  the ID instruction writes the register file.
- `id_wdst`  in  5  destination register of the ID instruction.
- `id_load`  in  1  the ID instruction is a load (dmld).
- `ex_taken`  in  1  the EX-stage branch/jump redirects the PC (pcchoose).
- `rfd1sel`, `rfd2sel`  out  2  forwarding selects: 00 register file, 01 EX/MEM result, 10 MEM/WB result, 11 never driven.
- `stall`  out  1  load-use hazard; hold IF/ID, insert bubble into ID/EX.
- `pc_en`  out  1  PC and IF/ID write enable; equals `!stall`.
- `flush`  out  1  bubble IF/ID and ID/EX this edge.
- `stall_cnt`, `flush_cnt`  out  CNT_W  saturating event counters.

## Operation
- The shadow pipeline has three entries: `ex`, `mem` and `wb`. Each entry holds {valid, wr, dst, load}.
- An entry matches source `s` when: valid && wr && dst==s && s!=0 && the matching `id_use_*` is set.
- Select for each source:
  - `ex` matches: `ex.load` → stall; otherwise 01.
  - Else if `mem` matches: 10.
  - Else: 00. The WB write is visible through the write-before-read register file.
  - The youngest match always wins.
- `stall` = `id_valid` && `ex` entry matches either source with `ex.load`=1 && !`ex_taken`.
- While `stall`=1, `rfd1sel`/`rfd2sel` are forced to 00.
- `flush` = `ex_taken`. Flush has priority over stall: when both would assert, `stall`=0, `pc_en`=1, `flush`=1.
- Shadow update on each edge:
  - `wb`<=`mem`, then `mem`<=`ex`.
  - `ex`<= ID fields (valid=`id_valid`) when !`stall` && !`flush`.
  - Otherwise `ex`<= invalid bubble.
- FSM with two states:
  - RUN → LU_STALL when `stall`=1.
  - LU_STALL → RUN unconditionally. The bubble has moved the load to `mem`, so a second consecutive stall from the same load is impossible.
  - If a new load-use hazard is seen in LU_STALL, flag `assert_fail` in simulation only.
- `stall_cnt` increments on every cycle with `stall`=1. `flush_cnt` increments on every cycle with `flush`=1. Both hold at all-ones.
- Reset values:
  - All shadow entries invalid; FSM in RUN.
  - `rfd1sel`=`rfd2sel`=00, `stall`=0, `pc_en`=1, `flush`=0, counters 0.
  - Reset applies immediately on `rst_n` low, mid-stall included.

## Timing
- `rfd*sel`, `stall`, `pc_en` and `flush` are combinational from the ID inputs and registered shadow state, valid in the same cycle.
- Consumers register them at the next edge into ID/EX.
- Load-use costs exactly one bubble cycle. On the following cycle the select is 10.
- A taken branch costs two bubbles, IF/ID and ID/EX, in one cycle. The shadow `ex` entry for the flushed ID instruction is never valid.
- Counters update one edge after the event.
- `rst_n` deassertion takes effect at the next rising edge; first shadow capture is on that edge.

## Structure
- The shared package holds:
  - the select encodings `SEL_RF`=2'b00, `SEL_EXMEM`=2'b01, `SEL_MEMWB`=2'b10;
  - the FSM state typedef {RUN, LU_STALL};
  - the shadow entry struct.
- One sub-module, `hazard_src_match`, instantiated twice, once per source operand. It computes the select and the load-use hit for a single source from the three shadow entries.

## Test plan
- `add r3,...` then `sub r5,r3,r1` → second instruction gets `rfd1sel`=01, `stall`=0.
- Producer of r3 followed by one unrelated instruction, then a reader of r3 as rt → `rfd2sel`=10.
- `lw r4` then `add r6,r4,r4` → `stall`=1 and `pc_en`=0 for one cycle. The next cycle gives `rfd1sel`=`rfd2sel`=10, and `stall_cnt` goes 0→1.
- `lw r4` in EX with reader in ID and `ex_taken`=1 in the same cycle → `flush`=1, `stall`=0, and the next cycle's `ex` entry is invalid.
- A writer to r0 followed by a reader of r0 → select 00, no stall. With `id_use_rs`=0 and a matching rs → select 00.
- Preload `stall_cnt` to 16'hFFFE and apply three load-use stalls → the counter holds at 16'hFFFF. Asserting `rst_n`=0 mid-stall → all outputs are at their reset values before the next edge.
